ram_bank: RTL and testbench
===========================

// Module: ram_bank
// PURPOSE
//  - Simple dual-port (1 write, 1 read) register-file RAM bank, single clock domain.
//  - Synchronous write port and registered synchronous read port, gated by a global enable.
//  - Used as a small local scratch/buffer memory. Default size: 8 words x 16 bits.
// PARAMETERS
//  - ADDR_BIT    3   width of addr_w / addr_r
//  - DATA_BIT   16   word width of d_w / d_r
//  - MEM_HEIGHT  8   number of words; legal range 1..2**ADDR_BIT
// PORTS
//  - clk     in   1          clock; all state updates on rising edge
//  - rst     in   1          reset, asynchronous, active-high
//  - en      in   1          bank enable; gates both read and write
//  - we      in   1          write enable (qualified by en)
//  - re      in   1          read enable (qualified by en)
//  - addr_w  in   ADDR_BIT   write address
//  - d_w     in   DATA_BIT   write data
//  - addr_r  in   ADDR_BIT   read address
//  - d_r     out  DATA_BIT   registered read data
// BEHAVIOUR
//  - Reset: rst=1 asynchronously forces d_r=0 and clears every memory word to 0.
//    Reset has priority over all other inputs. First post-reset edge acts normally.
//  - Write: at posedge, if en&we&(addr_w<MEM_HEIGHT): mem[addr_w] <= d_w.
//    An out-of-range addr_w is silently dropped; no other word changes.
//  - Read: at posedge, if en&re: d_r <= (addr_r<MEM_HEIGHT) ? mem[addr_r] : 0.
//    Latency is 1 cycle: the address is sampled at edge N, and data is valid after edge N.
//  - Hold: if !(en&re), d_r keeps its last value. If en=0, the bank is fully idle.
//  - X/unwritten: all words hold 0 until written, because reset initialises them.
//  - Simultaneous read and write to the same address in the same edge:
//    behaviour is set by RAM_BANK_BYPASS_EN (see CONFIGURATION).
//  - Different addresses in the same edge: the operations are independent.
//  - Reads and writes are never blocked. There is no handshake and no backpressure.
// CONFIGURATION
//  - RAM_BANK_BYPASS_EN defined: a same-address read-during-write returns the new data.
//    In that case d_r <= d_w (write-first).
//  - RAM_BANK_BYPASS_EN undefined: the read returns the old mem contents (read-first).
//    The write still completes.
// STRUCTURE
//  - Package ram_bank_pkg: default constants ADDR_BIT, DATA_BIT, MEM_HEIGHT.
//  - Package ram_bank_pkg also holds typedefs addr_t, data_t.
//  - Sub-module ram_bank_array: the storage array plus write decode, with reset clear.
//    It exposes a combinational read of one word.
//  - Top ram_bank: enable qualification, range checks, bypass mux, d_r register.
// TESTING
//  - Reset: assert rst mid-run with d_r=5 -> d_r=0 immediately, without waiting for a clk edge.
//    After reset, reading all addresses returns 0.
//  - Fill and readback: en=1, we=1, re=0; write addr k <- k for k=0..7, one per cycle.
//    Then re=1, read addr 0..7 -> d_r = 0,1,...,7, each valid one cycle after its address.
//  - Disable: en=0, we=1, write addr 3 <- 16'hBEEF, then en=1 and read addr 3.
//    -> d_r=3 (the write was blocked). While en=0 or re=0, d_r holds its last value.
//  - Collision: write addr 2 <- 16'h00AA and read addr 2 on the same edge (old value 2).
//    -> d_r=16'h00AA with RAM_BANK_BYPASS_EN, d_r=2 without it.
//    On the next read of addr 2, d_r=16'h00AA in both builds.
//  - Range: MEM_HEIGHT=6, ADDR_BIT=3; write addr 7 <- 16'h1234 -> no word changes.
//    Reading addr 7 -> d_r=0.

Source files
------------

// File: rtl/ram_bank_pkg.sv
// Shared constants and types for the ram_bank scratch memory.
// Optional build macro: RAM_BANK_BYPASS_EN (see ram_bank.sv).
package ram_bank_pkg;

  localparam int unsigned ADDR_BIT   = 3;
  localparam int unsigned DATA_BIT   = 16;
  localparam int unsigned MEM_HEIGHT = 8;

  typedef logic [ADDR_BIT-1:0] addr_t;
  typedef logic [DATA_BIT-1:0] data_t;

  // True when a zero-extended address selects an implemented word.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned height);
    return addr < height;
  endfunction

endpackage

// File: rtl/ram_bank_array.sv
// Storage array for ram_bank: per-word write decode, asynchronous clear,
// and a combinational read of one word (unimplemented addresses read 0).
module ram_bank_array #(
  parameter int unsigned ADDR_BIT   = ram_bank_pkg::ADDR_BIT,
  parameter int unsigned DATA_BIT   = ram_bank_pkg::DATA_BIT,
  parameter int unsigned MEM_HEIGHT = ram_bank_pkg::MEM_HEIGHT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_we,
  input  logic [ADDR_BIT-1:0] i_addr_w,
  input  logic [DATA_BIT-1:0] i_data_w,
  input  logic [ADDR_BIT-1:0] i_addr_r,
  output logic [DATA_BIT-1:0] o_data_r
);

  import ram_bank_pkg::*;

  logic [DATA_BIT-1:0] r_mem [MEM_HEIGHT];

  // Word storage: cleared on reset, one word written per qualified edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < MEM_HEIGHT; k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < MEM_HEIGHT; k++) begin
        if (i_we && (i_addr_w == ADDR_BIT'(k))) begin
          r_mem[k] <= i_data_w;
        end
      end
    end
  end

  // Read mux built as a compare loop so addresses past MEM_HEIGHT return 0.
  always_comb begin
    o_data_r = '0;
    for (int unsigned k = 0; k < MEM_HEIGHT; k++) begin
      if (i_addr_r == ADDR_BIT'(k)) begin
        o_data_r = r_mem[k];
      end
    end
  end

endmodule

// File: rtl/ram_bank.sv
// ram_bank: 1-write / 1-read register-file RAM with registered read data.
// Build macro RAM_BANK_BYPASS_EN: when defined, a same-address read during a
// write returns the new data (write-first); otherwise the old data (read-first).
module ram_bank #(
  parameter int unsigned ADDR_BIT   = ram_bank_pkg::ADDR_BIT,
  parameter int unsigned DATA_BIT   = ram_bank_pkg::DATA_BIT,
  parameter int unsigned MEM_HEIGHT = ram_bank_pkg::MEM_HEIGHT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                we,
  input  logic                re,
  input  logic [ADDR_BIT-1:0] addr_w,
  input  logic [DATA_BIT-1:0] d_w,
  input  logic [ADDR_BIT-1:0] addr_r,
  output logic [DATA_BIT-1:0] d_r
);

  import ram_bank_pkg::*;

  logic                w_wr_in_range;
  logic                w_rd_in_range;
  logic                w_wr;
  logic                w_rd;
  logic [DATA_BIT-1:0] w_arr_data;
  logic [DATA_BIT-1:0] w_rd_data;
  logic [DATA_BIT-1:0] r_d_r;

  // Enable qualification and address range checks.
  always_comb begin
    w_wr_in_range = addr_in_range(32'(addr_w), MEM_HEIGHT);
    w_rd_in_range = addr_in_range(32'(addr_r), MEM_HEIGHT);
    w_wr          = en & we & w_wr_in_range;
    w_rd          = en & re;
  end

  ram_bank_array #(
    .ADDR_BIT  (ADDR_BIT),
    .DATA_BIT  (DATA_BIT),
    .MEM_HEIGHT(MEM_HEIGHT)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wr),
    .i_addr_w(addr_w),
    .i_data_w(d_w),
    .i_addr_r(addr_r),
    .o_data_r(w_arr_data)
  );

  // Read data selection, including the same-address collision policy.
  always_comb begin
    w_rd_data = '0;
    if (w_rd_in_range) begin
      w_rd_data = w_arr_data;
`ifdef RAM_BANK_BYPASS_EN
      if (w_wr && (addr_w == addr_r)) begin
        w_rd_data = d_w;
      end
`endif
    end
  end

  // Registered read port: loads on a qualified read, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_r <= '0;
    end else if (w_rd) begin
      r_d_r <= w_rd_data;
    end
  end

  assign d_r = r_d_r;

endmodule

// File: tb/tb_ram_bank.sv
// Self-checking bench for ram_bank: an 8-word and a 6-word instance share
// stimulus and are compared with directed constants and an array model.
module tb_ram_bank;

  logic        clk;
  logic        rst;
  logic        en;
  logic        we;
  logic        re;
  logic [2:0]  aw;
  logic [15:0] dw;
  logic [2:0]  ar;
  logic [15:0] d_r8;
  logic [15:0] d_r6;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [15:0] m8 [8];
  logic [15:0] m6 [6];
  logic [15:0] e8;
  logic [15:0] e6;

  ram_bank #(.ADDR_BIT(3), .DATA_BIT(16), .MEM_HEIGHT(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .we(we), .re(re),
    .addr_w(aw), .d_w(dw), .addr_r(ar), .d_r(d_r8)
  );

  ram_bank #(.ADDR_BIT(3), .DATA_BIT(16), .MEM_HEIGHT(6)) dut6 (
    .clk(clk), .rst(rst), .en(en), .we(we), .re(re),
    .addr_w(aw), .d_w(dw), .addr_r(ar), .d_r(d_r6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m8[i] = '0;
    for (int i = 0; i < 6; i++) m6[i] = '0;
    e8 = '0;
    e6 = '0;
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model, settle.
  task automatic tick(input logic i_en, input logic i_we, input logic i_re,
                      input logic [2:0] i_aw, input logic [15:0] i_dw, input logic [2:0] i_ar);
    logic bypass;
    en = i_en; we = i_we; re = i_re; aw = i_aw; dw = i_dw; ar = i_ar;
    @(posedge clk);
`ifdef RAM_BANK_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    if (i_en && i_re) begin
      if (bypass && i_we && i_aw == i_ar) e8 = i_dw;
      else                                e8 = m8[i_ar];
      if (i_ar >= 6)                              e6 = '0;
      else if (bypass && i_we && i_aw == i_ar)    e6 = i_dw;
      else                                        e6 = m6[i_ar];
    end
    if (i_en && i_we) begin
      m8[i_aw] = i_dw;
      if (i_aw < 6) m6[i_aw] = i_dw;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 0; we = 0; re = 0; aw = 0; dw = 0; ar = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (d_r8 !== 16'h0) begin n_fail++; $display("FAIL reset_dr8 got=%h exp=0000", d_r8); end
    n_checks++;
    if (d_r6 !== 16'h0) begin n_fail++; $display("FAIL reset_dr6 got=%h exp=0000", d_r6); end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(1, 0, 1, 0, 16'h0, 3'(k));
      n_checks++;
      if (d_r8 !== 16'h0) begin n_fail++; $display("FAIL reset_read8 addr=%0d got=%h exp=0000", k, d_r8); end
    end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 8; k++) tick(1, 1, 0, 3'(k), 16'(k), 0);
    for (int k = 0; k < 8; k++) begin
      tick(1, 0, 1, 0, 16'h0, 3'(k));
      n_checks++;
      if (d_r8 !== 16'(k)) begin n_fail++; $display("FAIL fill_read8 addr=%0d got=%h exp=%h", k, d_r8, 16'(k)); end
      n_checks++;
      if (d_r6 !== ((k < 6) ? 16'(k) : 16'h0)) begin
        n_fail++; $display("FAIL fill_read6 addr=%0d got=%h exp=%h", k, d_r6, (k < 6) ? 16'(k) : 16'h0);
      end
    end
  endtask

  task automatic test_disable();
    tick(1, 0, 1, 0, 16'h0, 3'd1);
    tick(0, 1, 1, 3'd3, 16'hBEEF, 3'd3);
    n_checks++;
    if (d_r8 !== 16'd1) begin n_fail++; $display("FAIL disable_hold_en got=%h exp=0001", d_r8); end
    tick(1, 0, 0, 0, 16'h0, 3'd3);
    n_checks++;
    if (d_r8 !== 16'd1) begin n_fail++; $display("FAIL disable_hold_re got=%h exp=0001", d_r8); end
    tick(1, 0, 1, 0, 16'h0, 3'd3);
    n_checks++;
    if (d_r8 !== 16'd3) begin n_fail++; $display("FAIL disable_blocked_wr got=%h exp=0003", d_r8); end
  endtask

  task automatic test_collision();
    logic [15:0] exp;
`ifdef RAM_BANK_BYPASS_EN
    exp = 16'h00AA;
`else
    exp = 16'h0002;
`endif
    tick(1, 1, 1, 3'd2, 16'h00AA, 3'd2);
    n_checks++;
    if (d_r8 !== exp) begin n_fail++; $display("FAIL collision8 got=%h exp=%h", d_r8, exp); end
    n_checks++;
    if (d_r6 !== exp) begin n_fail++; $display("FAIL collision6 got=%h exp=%h", d_r6, exp); end
    tick(1, 0, 1, 0, 16'h0, 3'd2);
    n_checks++;
    if (d_r8 !== 16'h00AA) begin n_fail++; $display("FAIL collision_after8 got=%h exp=00aa", d_r8); end
    n_checks++;
    if (d_r6 !== 16'h00AA) begin n_fail++; $display("FAIL collision_after6 got=%h exp=00aa", d_r6); end
  endtask

  task automatic test_range();
    tick(1, 1, 0, 3'd7, 16'h1234, 0);
    tick(1, 0, 1, 0, 16'h0, 3'd7);
    n_checks++;
    if (d_r6 !== 16'h0) begin n_fail++; $display("FAIL range_read7_h6 got=%h exp=0000", d_r6); end
    n_checks++;
    if (d_r8 !== 16'h1234) begin n_fail++; $display("FAIL range_read7_h8 got=%h exp=1234", d_r8); end
    for (int k = 0; k < 6; k++) begin
      tick(1, 0, 1, 0, 16'h0, 3'(k));
      n_checks++;
      if (d_r6 !== m6[k]) begin n_fail++; $display("FAIL range_words6 addr=%0d got=%h exp=%h", k, d_r6, m6[k]); end
    end
  endtask

  task automatic test_async_reset();
    tick(1, 0, 1, 0, 16'h0, 3'd5);
    n_checks++;
    if (d_r8 !== 16'd5) begin n_fail++; $display("FAIL pre_reset_dr got=%h exp=0005", d_r8); end
    en = 0; re = 0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (d_r8 !== 16'h0) begin n_fail++; $display("FAIL async_reset8 got=%h exp=0000", d_r8); end
    n_checks++;
    if (d_r6 !== 16'h0) begin n_fail++; $display("FAIL async_reset6 got=%h exp=0000", d_r6); end
    model_clear();
    @(posedge clk);
    #3 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(1, 0, 1, 0, 16'h0, 3'(k));
      n_checks++;
      if (d_r8 !== 16'h0) begin n_fail++; $display("FAIL post_reset_read8 addr=%0d got=%h exp=0000", k, d_r8); end
      n_checks++;
      if (d_r6 !== 16'h0) begin n_fail++; $display("FAIL post_reset_read6 addr=%0d got=%h exp=0000", k, d_r6); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 16'($urandom), 3'($urandom_range(0, 7)));
      n_checks++;
      if (d_r8 !== e8) begin n_fail++; $display("FAIL random8 cyc=%0d got=%h exp=%h", n, d_r8, e8); end
      n_checks++;
      if (d_r6 !== e6) begin n_fail++; $display("FAIL random6 cyc=%0d got=%h exp=%h", n, d_r6, e6); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_disable();
    test_collision();
    test_range();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
